// File: rtl/cpu_isa_pkg.sv
// ISA helpers shared by the fetch and execute stages: opcodes, NOP,
// register-field slices and per-instruction register-use functions.
package cpu_isa_pkg;

  localparam logic [7:0] NOP = 8'h0A;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_BPZ   = 4'b1101;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_NOP   = 4'b1010;
  // ori and shift are identified by the low three opcode bits only
  localparam logic [2:0] SUB_ORI   = 3'b111;
  localparam logic [2:0] SUB_SHIFT = 3'b011;

  typedef struct packed {
    logic [3:0] rd_mask;  // one bit per architectural register read
    logic       wr_en;
    logic [1:0] dest;
  } reg_use_t;

  function automatic logic [3:0] opcode(input logic [7:0] ir);
    return ir[3:0];
  endfunction

  function automatic logic [1:0] rx(input logic [7:0] ir);
    return ir[7:6];
  endfunction

  function automatic logic [1:0] ry(input logic [7:0] ir);
    return ir[5:4];
  endfunction

  function automatic logic is_ori(input logic [7:0] ir);
    return ir[2:0] == SUB_ORI;
  endfunction

  function automatic logic is_shift(input logic [7:0] ir);
    return ir[2:0] == SUB_SHIFT;
  endfunction

  function automatic logic writes_reg(input logic [7:0] ir);
    case (opcode(ir))
      OP_LOAD, OP_ADD, OP_SUB, OP_NAND: return 1'b1;
      default:                          return is_ori(ir) || is_shift(ir);
    endcase
  endfunction

  // ori always targets R1; everything else that writes targets Rx
  function automatic logic [1:0] dest_reg(input logic [7:0] ir);
    return is_ori(ir) ? 2'd1 : rx(ir);
  endfunction

  function automatic logic reads_rx(input logic [7:0] ir);
    case (opcode(ir))
      OP_STORE, OP_ADD, OP_SUB, OP_NAND: return 1'b1;
      default:                           return is_shift(ir);
    endcase
  endfunction

  function automatic logic reads_ry(input logic [7:0] ir);
    case (opcode(ir))
      OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_NAND: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic src_is_r1(input logic [7:0] ir);
    return is_ori(ir);
  endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Combinational register-use decode of a single instruction register.
module reg_use_decode
  import cpu_isa_pkg::*;
(
  input  logic [7:0] ir,
  output reg_use_t   ru
);

  // Build the read mask and write destination from the ISA helpers
  always_comb begin
    ru = '0;
    if (reads_rx(ir))  ru.rd_mask[rx(ir)] = 1'b1;
    if (reads_ry(ir))  ru.rd_mask[ry(ir)] = 1'b1;
    if (src_is_r1(ir)) ru.rd_mask[1]      = 1'b1;
    ru.wr_en = writes_reg(ir);
    ru.dest  = dest_reg(ir);
  end

endmodule

// File: rtl/fetch_pipe.sv
// Pipeline front end: PC, IR1..IR4, data-hazard detect, retired counter.
module fetch_pipe
  import cpu_isa_pkg::reg_use_t;
#(
  parameter logic [7:0] NOP = 8'h0A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  inst_data,
  input  logic [7:0]  pc_target,
  input  logic        ALUPC1,
  input  logic        PCSel,
  input  logic        IR1Sel,
  input  logic        IR1Load,
  input  logic        IR2Sel,
  output logic [7:0]  pc,
  output logic [7:0]  ir1,
  output logic [7:0]  ir2,
  output logic [7:0]  ir3,
  output logic [7:0]  ir4,
  output logic        data_hazard,
  output logic [15:0] retired_count
);

  localparam int DEC = 3;  // IR1, IR2, IR3 are decoded; IR4 is write-first safe

  logic     [DEC-1:0][7:0] dec_ir;
  reg_use_t [DEC-1:0]      dec_ru;
  logic     [3:0]          wr_mask2, wr_mask3;

  assign dec_ir = {ir3, ir2, ir1};

  genvar g;
  generate
    for (g = 0; g < DEC; g++) begin : g_dec
      reg_use_decode u_dec (.ir(dec_ir[g]), .ru(dec_ru[g]));
    end
  endgenerate

  // Pending-write masks of IR2/IR3 against the IR1 read set
  always_comb begin
    wr_mask2    = dec_ru[1].wr_en ? (4'b0001 << dec_ru[1].dest) : 4'b0000;
    wr_mask3    = dec_ru[2].wr_en ? (4'b0001 << dec_ru[2].dest) : 4'b0000;
    data_hazard = |(dec_ru[0].rd_mask & (wr_mask2 | wr_mask3));
  end

  // Program counter: target load beats increment, else hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        pc <= 8'h00;
    else if (!PCSel)  pc <= pc_target;
    else if (ALUPC1)  pc <= pc + 8'd1;
  end

  // Instruction registers: IR1 hold/squash/fetch, IR2 bubble, IR3/IR4 drain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir1 <= NOP;
      ir2 <= NOP;
      ir3 <= NOP;
      ir4 <= NOP;
    end else begin
      if (IR1Load) ir1 <= IR1Sel ? inst_data : NOP;
      ir2 <= IR2Sel ? ir1 : NOP;
      ir3 <= ir2;
      ir4 <= ir3;
    end
  end

  // Saturating count of non-NOP instructions leaving IR4
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      retired_count <= 16'h0000;
    else if (ir4 != NOP && retired_count != 16'hFFFF)
      retired_count <= retired_count + 16'd1;
  end

endmodule
